sen_table_seq: RTL
==================

// Module: sen_table_seq
// PURPOSE
//  Upstream sequencer for the sine lookup ROM (24-bit entries, 302 deep, combinational read).
//  Walks the ROM address with a programmable stride and modulo-AMOUNT wrap.
//  Registers each ROM word into a one-deep output stage with a valid/ready handshake.
//  Feeds the processor's sample consumer: a fixed-length burst, or continuous until stopped.
// PARAMETERS
//  WIDTH   24                 sample/ROM word width; also width of rom_a
//  AMOUNT  302                number of ROM entries; address wraps modulo AMOUNT
//  ADDR_W  $clog2(AMOUNT)     internal pointer width (9 at default)
//  CNT_W   16                 burst-length counter width
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous, active-low reset
//  start         in   1        launch a burst; accepted only in IDLE
//  stop          in   1        abort a burst; honoured in RUN only
//  step          in   ADDR_W   address stride, latched on accepted start
//  length        in   CNT_W    samples to emit, latched on start; 0 = continuous
//  rom_a         out  WIDTH    ROM address, zero-extended pointer
//  rom_rd        in   WIDTH    ROM read data, same-cycle combinational
//  sample_data   out  WIDTH    registered sample
//  sample_valid  out  1        sample_data holds an unconsumed sample
//  sample_ready  in   1        consumer accepts when valid&&ready at clk edge
//  busy          out  1        state != IDLE
//  done          out  1        one-cycle pulse at burst completion or abort
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ptr=0, remaining=0, sample_data=0.
//   sample_valid=0, done=0, busy=0, rom_a=0. Latched step/length = 0.
//  States: IDLE, RUN, DRAIN (sen_pkg::seq_state_t).
//  IDLE: start=1 -> RUN; ptr<=0; step_q<=(step==0 ? 1 : min(step,AMOUNT-1)).
//   IDLE: remaining<=length; cont<=(length==0). stop is ignored in IDLE.
//   IDLE: start+stop in the same cycle starts the burst.
//  rom_a = {0,ptr} at all times; rom_rd is sampled in the same cycle (no ROM pipeline).
//  RUN capture: slot_free = !sample_valid || sample_ready.
//   If slot_free, then on the edge:
//   - sample_data<=rom_rd; sample_valid<=1.
//   - ptr<=(ptr+step_q>=AMOUNT) ? ptr+step_q-AMOUNT : ptr+step_q. Compute in ADDR_W+1 bits; never exceeds AMOUNT-1.
//   - if !cont: remaining<=remaining-1; if remaining==1 -> DRAIN.
//  Latency: start accepted at edge N -> sample ROM[0] valid after edge N+1.
//   Throughput is 1 sample/clk while sample_ready=1.
//  Backpressure: sample_ready=0 with sample_valid=1 holds sample_data, ptr and remaining stable.
//  stop in RUN -> DRAIN on that edge; no capture on that edge, even if the slot is free.
//  DRAIN: no captures. When !sample_valid, or valid&&ready on the edge -> IDLE with done=1 for one cycle.
//   The last sample is always delivered, never dropped.
//  start while busy: ignored, with no latching. step/length changes mid-burst have no effect.
//  Wrap examples: AMOUNT=302, step=5, ptr=300 -> 3; step=301 acts as a -1 stride.
//  Reset mid-burst: immediate return to reset values; an in-flight sample is discarded.
// CONFIGURATION
//  SEN_SEQ_MIRROR_EN defined:
//   - Adds input port mirror (1 bit), latched at start.
//   - When mirror_q=1, sample_data<=~rom_rd+1 (two's-complement negate, WIDTH bits) on odd laps.
//   - A lap toggles each time ptr wraps past AMOUNT-1.
//   - Lap parity resets to even on start.
//  SEN_SEQ_MIRROR_EN undefined: no mirror port; data is passed unmodified.
// STRUCTURE
//  sen_pkg contains:
//   - seq_state_t enum {IDLE,RUN,DRAIN}
//   - SEN_WIDTH=24, SEN_AMOUNT=302, SEN_ADDR_W localparam
//   - a function wrap_add(ptr,step) returning the modulo-AMOUNT sum
//  Sub-module sen_phase_acc: ptr register, stride latch, modulo wrap, lap flag.
//   The FSM and output stage stay in sen_table_seq.
//  The ROM is instantiated by the parent and connected via rom_a/rom_rd.
// TESTING
//  1 Burst: step=1, length=4, ready=1.
//    -> Samples ROM[0..3] on 4 consecutive cycles; done pulses once; busy=0 after.
//  2 Wrap: step=100, length=5.
//    -> Addresses 0,100,200,300,98; done after the 5th handshake.
//  3 Backpressure: hold ready=0 for 3 cycles after the first valid.
//    -> sample_data and rom_a stable; no sample lost or duplicated (compare against the ROM model).
//  4 Continuous: length=0, stop asserted after 10 accepted samples, ready=0 in DRAIN for 2 cycles.
//    -> 11th sample delivered; done 1 cycle after that handshake; no 12th sample.
//  5 Edge inputs: step=0 -> stride 1; step=400 -> stride 301.
//    -> start while busy ignored; start+stop in IDLE starts.
//  6 Async reset mid-burst (rst_n low between edges).
//    -> All outputs reset immediately; the next start begins at ROM[0].
//  With SEN_SEQ_MIRROR_EN: step=151, mirror=1, length=4.
//    -> Outputs ROM[0], ROM[151], -ROM[0], -ROM[151].

Source files
------------

// File: rtl/sen_pkg.sv
// Shared types and constants for the sine-table sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sen_pkg;

  localparam int SEN_WIDTH  = 24;
  localparam int SEN_AMOUNT = 302;
  localparam int SEN_ADDR_W = $clog2(SEN_AMOUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // Modulo-SEN_AMOUNT pointer advance; one extra bit keeps the raw sum from overflowing.
  function automatic logic [SEN_ADDR_W-1:0] wrap_add(input logic [SEN_ADDR_W-1:0] ptr,
                                                     input logic [SEN_ADDR_W-1:0] step);
    logic [SEN_ADDR_W:0] sum;
    sum = {1'b0, ptr} + {1'b0, step};
    if (sum >= (SEN_ADDR_W+1)'(SEN_AMOUNT)) begin
      sum = sum - (SEN_ADDR_W+1)'(SEN_AMOUNT);
    end
    return sum[SEN_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sen_phase_acc.sv
// ROM pointer accumulator: stride latch, modulo-AMOUNT wrap and lap parity flag.
// Latency: ptr updates on the edge where advance is high; load clears it on the same edge.
// Backpressure: ptr holds whenever advance is low, so the parent stalls it by withholding advance.
module sen_phase_acc
  import sen_pkg::*;
#(
  parameter int AMOUNT = SEN_AMOUNT,
  parameter int ADDR_W = $clog2(AMOUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] step,
  output logic [ADDR_W-1:0] ptr,
  output logic              lap
);

  localparam logic [ADDR_W:0]   AMT_X    = (ADDR_W+1)'(AMOUNT);
  localparam logic [ADDR_W-1:0] MAX_STEP = ADDR_W'(AMOUNT - 1);

  logic [ADDR_W-1:0] step_q;
  logic [ADDR_W-1:0] step_clamp;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [ADDR_W:0]   sum;
  logic [ADDR_W:0]   diff;
  logic              wrap;

  // Zero stride would stall the walk, so it becomes 1; oversize strides saturate at AMOUNT-1 (a -1 step).
  always_comb begin
    step_clamp = step;
    if (step == '0) begin
      step_clamp = ADDR_W'(1);
    end else if (step > MAX_STEP) begin
      step_clamp = MAX_STEP;
    end
  end

  // Next pointer in ADDR_W+1 bits; a single subtract suffices since ptr and step_q are both below AMOUNT.
  always_comb begin
    sum     = {1'b0, ptr} + {1'b0, step_q};
    diff    = sum - AMT_X;
    wrap    = (sum >= AMT_X);
    ptr_nxt = wrap ? diff[ADDR_W-1:0] : sum[ADDR_W-1:0];
  end

  // Pointer, stride and lap parity; a new burst always restarts at entry 0 on an even lap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      step_q <= '0;
      lap    <= 1'b0;
    end else if (load) begin
      ptr    <= '0;
      step_q <= step_clamp;
      lap    <= 1'b0;
    end else if (advance) begin
      ptr <= ptr_nxt;
      if (wrap) begin
        lap <= ~lap;
      end
    end
  end

endmodule

// File: rtl/sen_table_seq.sv
// Sine ROM sequencer: strided modulo walk of the ROM into a one-deep valid/ready output register.
// Latency: start accepted at edge N gives ROM[0] valid after edge N+1; 1 sample/clk while ready.
// Backpressure: ready low with valid high freezes data, pointer and count. Option: SEN_SEQ_MIRROR_EN.
module sen_table_seq
  import sen_pkg::*;
#(
  parameter int WIDTH  = SEN_WIDTH,
  parameter int AMOUNT = SEN_AMOUNT,
  parameter int ADDR_W = $clog2(AMOUNT),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] step,
  input  logic [CNT_W-1:0]  length,
`ifdef SEN_SEQ_MIRROR_EN
  input  logic              mirror,
`endif
  output logic [WIDTH-1:0]  rom_a,
  input  logic [WIDTH-1:0]  rom_rd,
  output logic [WIDTH-1:0]  sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done
);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic              cont;
  logic              load;
  logic              capture;
  logic              go_idle;
  logic              slot_free;
  logic [ADDR_W-1:0] ptr;
  logic              lap;
  logic [WIDTH-1:0]  cap_data;

  assign slot_free = !sample_valid || sample_ready;
  assign busy      = (state != IDLE);
  assign rom_a     = {{(WIDTH-ADDR_W){1'b0}}, ptr};

  sen_phase_acc #(
    .AMOUNT (AMOUNT),
    .ADDR_W (ADDR_W)
  ) u_phase_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .advance (capture),
    .step    (step),
    .ptr     (ptr),
    .lap     (lap)
  );

`ifdef SEN_SEQ_MIRROR_EN
  logic mirror_q;

  // Mirror mode is fixed for the whole burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mirror_q <= 1'b0;
    end else if (load) begin
      mirror_q <= mirror;
    end
  end

  // Odd laps emit the negated word so the table sweeps both half-waves.
  always_comb begin
    cap_data = rom_rd;
    if (mirror_q && lap) begin
      cap_data = ~rom_rd + WIDTH'(1);
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign cap_data   = rom_rd;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle strobes; stop wins over a capture in RUN, and DRAIN waits for the last handshake.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    go_idle   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = DRAIN;
        end else if (slot_free) begin
          capture = 1'b1;
          if (!cont && remaining == CNT_W'(1)) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (slot_free) begin
          go_idle   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst length bookkeeping; continuous bursts never count down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      cont      <= 1'b0;
    end else if (load) begin
      remaining <= length;
      cont      <= (length == '0);
    end else if (capture && !cont) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

  // One-deep output register: refilled on capture, emptied by a handshake without a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else if (capture) begin
      sample_data  <= cap_data;
      sample_valid <= 1'b1;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

  // Completion pulse for the cycle after leaving DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= go_idle;
    end
  end

endmodule
